// File: rtl/instr_queue_mt_pkg.sv
// instr_queue_mt_pkg: shared widths and the fetch entry type for the
// multi-thread instruction queue and its consumers (decode).
// XLEN / INSTR_WIDTH default to 32 unless the build defines them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package instr_queue_mt_pkg;

    localparam int IQ_NUM_THREADS = 4;
    localparam int IQ_DEPTH       = 4;
    localparam int THREAD_WIDTH   = $clog2(IQ_NUM_THREADS);
    localparam int XLEN           = `XLEN;
    localparam int INSTR_WIDTH    = `INSTR_WIDTH;

    // One fetched instruction as seen by decode.
    typedef struct packed {
        logic [THREAD_WIDTH-1:0] tid;
        logic [XLEN-1:0]         pc;
        logic [INSTR_WIDTH-1:0]  instr;
    } iq_entry_t;

endpackage

// File: rtl/instr_queue_mt_rr_arbiter.sv
// instr_queue_mt_rr_arbiter: round-robin grant over a request vector.
// Grants the first requester strictly after the last-served thread,
// wrapping modulo NUM_THREADS. Last-served resets to NUM_THREADS-1 so
// thread 0 wins first.
module instr_queue_mt_rr_arbiter #(
    parameter int NUM_THREADS = 4,
    localparam int TW = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THREADS-1:0] i_req,
    input  logic                   i_upd,
    input  logic [TW-1:0]          i_upd_tid,
    output logic                   o_grant_valid,
    output logic [TW-1:0]          o_grant
);

    logic [TW-1:0] r_last;
    logic [TW-1:0] w_idx;
    logic [TW-1:0] w_grant;
    logic          w_found;

    // Scan from last+1 upward; offset NUM_THREADS wraps back to last itself.
    always_comb begin
        w_idx   = '0;
        w_grant = '0;
        w_found = 1'b0;
        for (int off = 1; off <= NUM_THREADS; off++) begin
            w_idx = r_last + TW'(off);
            if (!w_found && i_req[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign o_grant_valid = w_found;
    assign o_grant       = w_grant;

    // Last-served register, loaded whenever an entry is consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= TW'(NUM_THREADS - 1);
        end else if (i_upd) begin
            r_last <= i_upd_tid;
        end
    end

endmodule

// File: rtl/instr_queue_mt.sv
// instr_queue_mt: per-thread circular instruction queues feeding decode
// through a round-robin arbiter, with per-thread flush.
// Handshakes: a write is taken on wr_valid_i && wr_ready_o; an entry is
// consumed on rd_valid_o && rd_ack_i. Flush of a thread overrides both.
// Optional macro IQ_BYPASS_EN: when all queues are empty, a valid,
// non-flushed write is presented to decode in the same cycle.
module instr_queue_mt
    import instr_queue_mt_pkg::*;
#(
    parameter int NUM_THREADS = IQ_NUM_THREADS,
    parameter int DEPTH       = IQ_DEPTH,
    parameter int XLEN        = instr_queue_mt_pkg::XLEN,
    parameter int INSTR_WIDTH = instr_queue_mt_pkg::INSTR_WIDTH,
    localparam int TW = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [TW-1:0]          wr_tid_i,
    input  logic [XLEN-1:0]        wr_pc_i,
    input  logic [INSTR_WIDTH-1:0] wr_instr_i,
    input  logic [NUM_THREADS-1:0] flush_i,
    output logic [NUM_THREADS-1:0] full_o,
    output logic                   rd_valid_o,
    input  logic                   rd_ack_i,
    output logic [TW-1:0]          rd_tid_o,
    output logic [XLEN-1:0]        rd_pc_o,
    output logic [INSTR_WIDTH-1:0] rd_instr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;   // MSB is the wrap bit

    logic [PW-1:0]          r_wptr  [NUM_THREADS];
    logic [PW-1:0]          r_rptr  [NUM_THREADS];
    logic [XLEN-1:0]        r_pc    [NUM_THREADS][DEPTH];
    logic [INSTR_WIDTH-1:0] r_instr [NUM_THREADS][DEPTH];

    logic [NUM_THREADS-1:0] w_empty;
    logic [NUM_THREADS-1:0] w_full;
    logic [NUM_THREADS-1:0] w_elig;
    logic                   w_q_valid;
    logic [TW-1:0]          w_grant;
    logic                   w_byp;
    logic                   w_wr_fire;
    logic                   w_rd_fire;
    logic                   w_upd;
    logic [TW-1:0]          w_upd_tid;

    // Per-thread empty/full from pointer comparison; flush masks eligibility.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_empty[t] = (r_wptr[t] == r_rptr[t]);
            w_full[t]  = (r_wptr[t][AW-1:0] == r_rptr[t][AW-1:0]) &&
                         (r_wptr[t][PW-1] != r_rptr[t][PW-1]);
        end
        w_elig = ~w_empty & ~flush_i;
    end

    assign full_o     = w_full;
    assign wr_ready_o = !w_full[wr_tid_i];

    instr_queue_mt_rr_arbiter #(
        .NUM_THREADS (NUM_THREADS)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_req         (w_elig),
        .i_upd         (w_upd),
        .i_upd_tid     (w_upd_tid),
        .o_grant_valid (w_q_valid),
        .o_grant       (w_grant)
    );

`ifdef IQ_BYPASS_EN
    assign w_byp = (&w_empty) && wr_valid_i && !flush_i[wr_tid_i];
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed entry that decode takes this cycle is never stored.
    assign w_wr_fire = wr_valid_i && wr_ready_o && !flush_i[wr_tid_i] &&
                       !(w_byp && rd_ack_i);
    assign w_rd_fire = w_q_valid && rd_ack_i;
    assign w_upd     = rd_valid_o && rd_ack_i;
    assign w_upd_tid = w_byp ? wr_tid_i : w_grant;

    // Read-side mux: queue head of the granted thread, bypass, or zeros.
    always_comb begin
        rd_valid_o = 1'b0;
        rd_tid_o   = '0;
        rd_pc_o    = '0;
        rd_instr_o = '0;
        if (w_q_valid) begin
            rd_valid_o = 1'b1;
            rd_tid_o   = w_grant;
            rd_pc_o    = r_pc[w_grant][r_rptr[w_grant][AW-1:0]];
            rd_instr_o = r_instr[w_grant][r_rptr[w_grant][AW-1:0]];
        end else if (w_byp) begin
            rd_valid_o = 1'b1;
            rd_tid_o   = wr_tid_i;
            rd_pc_o    = wr_pc_i;
            rd_instr_o = wr_instr_i;
        end
    end

    // Pointer update; flush collapses the thread and wins over read/write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_wptr[t] <= '0;
                r_rptr[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (flush_i[t]) begin
                    r_rptr[t] <= r_wptr[t];
                end else begin
                    if (w_wr_fire && (wr_tid_i == TW'(t))) begin
                        r_wptr[t] <= r_wptr[t] + PW'(1);
                    end
                    if (w_rd_fire && (w_grant == TW'(t))) begin
                        r_rptr[t] <= r_rptr[t] + PW'(1);
                    end
                end
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_pc[wr_tid_i][r_wptr[wr_tid_i][AW-1:0]]    <= wr_pc_i;
            r_instr[wr_tid_i][r_wptr[wr_tid_i][AW-1:0]] <= wr_instr_i;
        end
    end

endmodule
